// File: rtl/mat_pkg.sv
// Shared definitions for the matrix datapath: loader state type, index widths
// and the element format defaults that the transpose stage also uses.
package mat_pkg;

    localparam int DATA_WIDTH_DEF = 16;
    localparam int FIXED_PNT_DEF  = 8;

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } ld_state_t;

    // A single-row or single-column matrix still needs a 1-bit index
    function automatic int row_w(input int num_rows);
        return (num_rows > 1) ? $clog2(num_rows) : 1;
    endfunction

    function automatic int col_w(input int num_cols);
        return (num_cols > 1) ? $clog2(num_cols) : 1;
    endfunction

endpackage

// File: rtl/rc_index_counter.sv
// Row-major row/col index counter: col wraps into row, clear wins over enable.
module rc_index_counter
    import mat_pkg::*;
#(
    parameter int NUM_ROWS = 64,
    parameter int NUM_COLS = 96,
    localparam int RW = row_w(NUM_ROWS),
    localparam int CW = col_w(NUM_COLS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          clr,
    output logic [RW-1:0] row,
    output logic [CW-1:0] col,
    output logic          is_last
);

    localparam logic [RW-1:0] ROW_MAX = RW'(NUM_ROWS - 1);
    localparam logic [CW-1:0] COL_MAX = CW'(NUM_COLS - 1);

    logic col_at_max;
    logic row_at_max;

    assign col_at_max = (col == COL_MAX);
    assign row_at_max = (row == ROW_MAX);
    assign is_last    = col_at_max && row_at_max;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            row <= '0;
            col <= '0;
        end else if (en) begin
            if (col_at_max) begin
                col <= '0;
                row <= row_at_max ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mat_stream_loader.sv
// Streams row-major elements into a registered matrix and holds each complete
// frame until acknowledged; frame length is checked against in_last.
//
// state | meaning
// FILL  | accepting elements, in_ready=1
// FULL  | complete frame held on mat_out, mat_valid=1, waiting for mat_ack
module mat_stream_loader
    import mat_pkg::*;
#(
    parameter int NUM_ROWS   = 64,
    parameter int NUM_COLS   = 96,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int FIXED_PNT  = FIXED_PNT_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic signed [DATA_WIDTH-1:0] in_data,
    input  logic                         in_valid,
    input  logic                         in_last,
    output logic                         in_ready,
    output logic signed [DATA_WIDTH-1:0] mat_out [NUM_ROWS][NUM_COLS],
    output logic                         mat_valid,
    input  logic                         mat_ack,
    output logic                         err_len
);

    localparam int RW = row_w(NUM_ROWS);
    localparam int CW = col_w(NUM_COLS);

    // The fractional point only travels with the data; it must fit the word
    generate
        if (FIXED_PNT < 0 || FIXED_PNT >= DATA_WIDTH) begin : g_bad_fixed_pnt
            $error("mat_stream_loader: FIXED_PNT out of range for DATA_WIDTH");
        end
    endgenerate

    ld_state_t     state;
    logic [RW-1:0] row;
    logic [CW-1:0] col;
    logic          is_last;
    logic          accept;
    logic          frame_end;
    logic          frame_ok;

    assign in_ready  = (state == FILL) && !rst;
    assign mat_valid = (state == FULL);
    assign accept    = in_valid && in_ready;
    // Either marker ends the frame; only both together make a good one
    assign frame_end = accept && (in_last || is_last);
    assign frame_ok  = accept && in_last && is_last;

    rc_index_counter #(
        .NUM_ROWS (NUM_ROWS),
        .NUM_COLS (NUM_COLS)
    ) u_idx (
        .clk     (clk),
        .rst     (rst),
        .en      (accept),
        .clr     (frame_end),
        .row     (row),
        .col     (col),
        .is_last (is_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= FILL;
            err_len <= 1'b0;
        end else begin
            err_len <= frame_end && !frame_ok;
            case (state)
                FILL:    if (frame_ok) state <= FULL;
                FULL:    if (mat_ack)  state <= FILL;
                default: state <= FILL;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NUM_ROWS; r++) begin
                for (int c = 0; c < NUM_COLS; c++) begin
                    mat_out[r][c] <= '0;
                end
            end
        end else if (accept) begin
            mat_out[row][col] <= in_data;
        end
    end

endmodule

// File: tb/tb_mat_stream_loader.sv
// Directed bench for mat_stream_loader on a 2x3 matrix with hand-computed frames.
module tb_mat_stream_loader;

    localparam int NR = 2;
    localparam int NC = 3;
    localparam int DW = 16;

    logic                 clk = 1'b0;
    logic                 rst;
    logic signed [DW-1:0] in_data;
    logic                 in_valid;
    logic                 in_last;
    logic                 in_ready;
    logic signed [DW-1:0] mat_out [NR][NC];
    logic                 mat_valid;
    logic                 mat_ack;
    logic                 err_len;

    int vectors = 0;
    int miscompares = 0;

    mat_stream_loader #(
        .NUM_ROWS   (NR),
        .NUM_COLS   (NC),
        .DATA_WIDTH (DW),
        .FIXED_PNT  (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .mat_out   (mat_out),
        .mat_valid (mat_valid),
        .mat_ack   (mat_ack),
        .err_len   (err_len)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int d, input logic last);
        in_valid = 1'b1;
        in_data  = DW'(d);
        in_last  = last;
        tick();
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_last  = 1'b0;
        tick();
    endtask

    task automatic chk_mat(input string tag, input int e [6]);
        int v;
        for (int r = 0; r < NR; r++) begin
            for (int c = 0; c < NC; c++) begin
                v = mat_out[r][c];
                chk($sformatf("%s[%0d][%0d]", tag, r, c), v, e[r*NC + c]);
            end
        end
    endtask

    task automatic ack();
        mat_ack = 1'b1;
        tick();
        mat_ack = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = '0; mat_ack = 1'b0;
        tick();
        tick();
        chk("rst_in_ready", in_ready, 0);
        chk("rst_mat_valid", mat_valid, 0);
        chk("rst_err_len", err_len, 0);
        chk_mat("rst_mat", '{0, 0, 0, 0, 0, 0});
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", in_ready, 1);

        // continuous fill
        for (int i = 1; i <= 5; i++) send(i, 1'b0);
        chk("fill_valid_early", mat_valid, 0);
        send(6, 1'b1);
        chk("fill_mat_valid", mat_valid, 1);
        chk("fill_in_ready", in_ready, 0);
        chk("fill_err_len", err_len, 0);
        chk_mat("fill_mat", '{1, 2, 3, 4, 5, 6});

        // hold while FULL with valid data on the bus, then ack in the same situation
        for (int i = 0; i < 5; i++) send(99, 1'b0);
        chk("hold_valid", mat_valid, 1);
        chk_mat("hold_mat", '{1, 2, 3, 4, 5, 6});
        in_valid = 1'b1; in_data = DW'(99);
        ack();
        in_valid = 1'b0;
        chk("ack_mat_valid", mat_valid, 0);
        chk("ack_in_ready", in_ready, 1);
        chk("ack_no_write", 32'(mat_out[0][0]), 32'(1));

        // mat_ack in FILL does nothing
        ack();
        chk("ack_fill_ready", in_ready, 1);

        // gapped negative frame
        for (int i = 1; i <= 6; i++) begin
            send(-i, i == 6);
            if (i < 6) idle();
        end
        chk("gap_mat_valid", mat_valid, 1);
        chk_mat("gap_mat", '{-1, -2, -3, -4, -5, -6});
        ack();

        // early in_last on the 4th element
        for (int i = 0; i < 3; i++) send(20 + i, 1'b0);
        send(23, 1'b1);
        chk("early_err", err_len, 1);
        chk("early_valid", mat_valid, 0);
        idle();
        chk("early_err_pulse", err_len, 0);
        for (int i = 10; i <= 15; i++) send(i, i == 15);
        chk("early_next_valid", mat_valid, 1);
        chk("early_next_err", err_len, 0);
        chk_mat("early_next_mat", '{10, 11, 12, 13, 14, 15});
        ack();

        // six elements without in_last
        for (int i = 30; i <= 35; i++) send(i, 1'b0);
        chk("miss_err", err_len, 1);
        chk("miss_valid", mat_valid, 0);
        chk("miss_stale", 32'(mat_out[1][2]), 32'(35));
        idle();
        chk("miss_err_pulse", err_len, 0);
        chk("miss_valid_after", mat_valid, 0);
        for (int i = 40; i <= 45; i++) send(i, i == 45);
        chk("miss_next_valid", mat_valid, 1);
        chk_mat("miss_next_mat", '{40, 41, 42, 43, 44, 45});
        ack();

        // reset after three elements
        for (int i = 50; i <= 52; i++) send(i, 1'b0);
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        chk("mid_rst_ready", in_ready, 0);
        chk("mid_rst_valid", mat_valid, 0);
        chk_mat("mid_rst_mat", '{0, 0, 0, 0, 0, 0});
        rst = 1'b0;
        for (int i = 7; i <= 9; i++) begin
            send(i, 1'b0);
            chk($sformatf("mid_rst_err_%0d", i), err_len, 0);
        end
        chk("mid_rst_zero_tail", 32'(mat_out[1][0]), 32'(0));
        for (int i = 10; i <= 12; i++) begin
            send(i, i == 12);
            chk($sformatf("mid_rst_err_%0d", i), err_len, 0);
        end
        chk("mid_rst_valid_end", mat_valid, 1);
        chk_mat("mid_rst_final", '{7, 8, 9, 10, 11, 12});
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
